// File: rtl/fp_pkg.sv
// Shared FP32 definitions: rounding-mode encodings, field layout, integer limits
// and the converter state enumeration.
package fp_pkg;

    localparam logic [1:0] RM_NEAREST_EVEN = 2'b00;
    localparam logic [1:0] RM_DOWN         = 2'b01;
    localparam logic [1:0] RM_UP           = 2'b10;
    localparam logic [1:0] RM_ZERO         = 2'b11;

    localparam int FP_SIGN_POS = 31;
    localparam int FP_EXP_W    = 8;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_FRAC_W   = 23;
    localparam int FP_MANT_W   = 24;
    localparam int EXP_BIAS    = 127;

    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    // Right shifts beyond this leave I, G at zero; only sticky matters past it.
    localparam logic [4:0] MAX_RSHIFT = 5'd26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/fp_round_decide.sv
// Rounding increment decision from lsb/guard/sticky, shared with the FP adder.
module fp_round_decide
    import fp_pkg::*;
(
    input  logic [1:0] RMode,
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    output logic       inc
);

    always_comb begin
        inc = 1'b0;
        case (RMode)
            RM_NEAREST_EVEN: inc = guard & (sticky | lsb);
            RM_DOWN:         inc = (guard | sticky) & sign;
            RM_UP:           inc = (guard | sticky) & ~sign;
            default:         inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_to_int.sv
// FP32 -> signed INT32 converter with iterative alignment and ready/valid handshakes.
// Define FP2INT_FLAGS_EN to add the Invalid/Inexact flag ports.
module fp_to_int
    import fp_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] Data_In,
    input  logic        Valid_In,
    input  logic [1:0]  RMode,
    output logic        Ready_Out,
    output logic [31:0] Data_Out,
    output logic        Valid_Out,
`ifdef FP2INT_FLAGS_EN
    output logic        Invalid,
    output logic        Inexact,
`endif
    input  logic        Ready_In
);

    localparam logic [5:0] STEP_W = 6'(STEP);

    state_t      r_state;
    logic [31:0] r_I;
    logic        r_G;
    logic        r_S;
    logic        r_sign;
    logic [1:0]  r_rmode;
    logic        r_left;
    logic [4:0]  r_rem;

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_frac;
    logic [23:0] w_mant;
    logic        w_left;
    logic [7:0]  w_rsh;
    logic [4:0]  w_sh;
    logic        w_special;
    logic [31:0] w_spec_val;
    logic [5:0]  w_k;
    logic [31:0] w_lowmask;
    logic        w_gbit;
    logic        w_lost;
    logic        w_inc;
    logic [32:0] w_mag;
    logic        w_sat;
    logic [31:0] w_res;

    assign Ready_Out = (r_state == IDLE);

    assign w_sign = Data_In[FP_SIGN_POS];
    assign w_exp  = Data_In[FP_EXP_LSB +: FP_EXP_W];
    assign w_frac = Data_In[FP_FRAC_W-1:0];
    assign w_mant = {(w_exp != 8'd0), w_frac};

    // e > 23 <=> E > 150; left shifts of a normal in range are at most 7.
    assign w_left = (w_exp > 8'd150);
    assign w_rsh  = 8'd150 - w_exp;
    assign w_sh   = w_left ? 5'(w_exp - 8'd150)
                           : ((w_rsh > 8'(MAX_RSHIFT)) ? MAX_RSHIFT : w_rsh[4:0]);

    assign w_special = (w_exp == 8'hFF) || (w_exp >= 8'd158) || (w_exp == 8'd0);

    always_comb begin
        w_spec_val = INT32_MAX;
        if (w_exp == 8'd0)
            w_spec_val = '0;
        else if (w_sign || ((w_exp == 8'hFF) && (w_frac != '0)))
            w_spec_val = INT32_MIN;
    end

`ifdef FP2INT_FLAGS_EN
    logic w_spec_inv;
    logic w_spec_inx;
    assign w_spec_inv = (w_exp == 8'hFF) || ((w_exp >= 8'd158) && (Data_In != 32'hCF00_0000));
    assign w_spec_inx = (w_exp == 8'd0) && (w_frac != '0);
`endif

    assign w_k       = ({1'b0, r_rem} > STEP_W) ? STEP_W : {1'b0, r_rem};
    assign w_lowmask = (32'd1 << (w_k - 6'd1)) - 32'd1;
    assign w_gbit    = |(r_I & (32'd1 << (w_k - 6'd1)));
    assign w_lost    = |(r_I & w_lowmask);

    fp_round_decide u_round (
        .RMode (r_rmode),
        .sign  (r_sign),
        .lsb   (r_I[0]),
        .guard (r_G),
        .sticky(r_S),
        .inc   (w_inc)
    );

    assign w_mag = {1'b0, r_I} + 33'(w_inc);
    assign w_sat = ~r_sign && (w_mag > 33'h0_7FFF_FFFF);
    assign w_res = r_sign ? (~w_mag[31:0] + 32'd1) : w_mag[31:0];

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state   <= IDLE;
            r_I       <= '0;
            r_G       <= 1'b0;
            r_S       <= 1'b0;
            r_sign    <= 1'b0;
            r_rmode   <= RM_NEAREST_EVEN;
            r_left    <= 1'b0;
            r_rem     <= '0;
            Data_Out  <= '0;
            Valid_Out <= 1'b0;
`ifdef FP2INT_FLAGS_EN
            Invalid   <= 1'b0;
            Inexact   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (Valid_In) begin
                        r_sign  <= w_sign;
                        r_rmode <= RMode;
                        r_I     <= {8'd0, w_mant};
                        r_G     <= 1'b0;
                        r_S     <= 1'b0;
                        if (w_special) begin
                            Data_Out  <= w_spec_val;
                            Valid_Out <= 1'b1;
`ifdef FP2INT_FLAGS_EN
                            Invalid   <= w_spec_inv;
                            Inexact   <= w_spec_inx;
`endif
                            r_state   <= OUT;
                        end else begin
                            r_left  <= w_left;
                            r_rem   <= w_sh;
                            r_state <= (w_sh == 5'd0) ? ROUND : ALIGN;
                        end
                    end
                end
                // Shift up to STEP bits; right shifts feed guard and sticky.
                ALIGN: begin
                    if (r_left) begin
                        r_I <= r_I << w_k;
                    end else begin
                        r_I <= r_I >> w_k;
                        r_G <= w_gbit;
                        r_S <= r_S | r_G | w_lost;
                    end
                    r_rem <= r_rem - 5'(w_k);
                    if (r_rem == 5'(w_k))
                        r_state <= ROUND;
                end
                ROUND: begin
                    Data_Out  <= w_sat ? INT32_MAX : w_res;
                    Valid_Out <= 1'b1;
`ifdef FP2INT_FLAGS_EN
                    Invalid   <= w_sat;
                    Inexact   <= (r_G | r_S) & ~w_sat;
`endif
                    r_state   <= OUT;
                end
                OUT: begin
                    if (Ready_In) begin
                        Valid_Out <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_int.sv
// Scoreboard bench for fp_to_int: directed cases, back-pressure, mid-op reset, random traffic.
module tb_fp_to_int;

    localparam int STEP = 8;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [31:0] Data_In = '0;
    logic        Valid_In = 1'b0;
    logic [1:0]  RMode = 2'b00;
    logic        Ready_In = 1'b0;
    logic        Ready_Out;
    logic [31:0] Data_Out;
    logic        Valid_Out;
`ifdef FP2INT_FLAGS_EN
    logic        Invalid;
    logic        Inexact;
`endif

    fp_to_int #(.STEP(STEP)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Data_In  (Data_In),
        .Valid_In (Valid_In),
        .RMode    (RMode),
        .Ready_Out(Ready_Out),
        .Data_Out (Data_Out),
        .Valid_Out(Valid_Out),
`ifdef FP2INT_FLAGS_EN
        .Invalid  (Invalid),
        .Inexact  (Inexact),
`endif
        .Ready_In (Ready_In)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        inv;
        logic        inx;
        int          acc;
        int          lat;
        logic [31:0] din;
    } exp_t;

    exp_t exp_q[$];
    int   npass = 0;
    int   ntot  = 0;
    bit   rand_ready = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        ntot++;
        if (act === expv) npass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    endtask

    // Reference: value = m24 * 2^(e-23), rounded by comparing the discarded fraction to one half.
    function automatic exp_t model(input logic [31:0] d, input logic [1:0] rm);
        exp_t   r;
        bit     s;
        int     E, e, sh, shc, cmph;
        longint m, q, rem, mag;
        bit     up, nz;
        r.data = '0; r.inv = 0; r.inx = 0; r.acc = 0; r.lat = 1; r.din = d;
        s = d[31];
        E = int'(d[30:23]);
        m = longint'({1'b1, d[22:0]});
        if (E == 255) begin
            r.inv  = 1;
            r.data = ((d[22:0] != 0) || s) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (E == 0) begin
            r.inx = (d[22:0] != 0);
        end else begin
            e = E - 127;
            if (e >= 31) begin
                if (d == 32'hCF00_0000) r.data = 32'h8000_0000;
                else begin
                    r.inv  = 1;
                    r.data = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                end
            end else begin
                nz = 0; up = 0;
                if (e >= 23) begin
                    sh  = e - 23;
                    mag = m << sh;
                end else begin
                    sh = 23 - e;
                    if (sh >= 40) begin
                        q = 0; rem = m; cmph = -1;
                    end else begin
                        q   = m >> sh;
                        rem = m - (q << sh);
                        if (2 * rem > (longint'(1) << sh)) cmph = 1;
                        else if (2 * rem == (longint'(1) << sh)) cmph = 0;
                        else cmph = -1;
                    end
                    nz = (rem != 0);
                    case (rm)
                        2'b00: up = (cmph > 0) || ((cmph == 0) && q[0]);
                        2'b01: up = nz && s;
                        2'b10: up = nz && !s;
                        default: up = 0;
                    endcase
                    mag = q + longint'(up);
                end
                shc   = (sh > 26) ? 26 : sh;
                r.lat = 2 + (shc + STEP - 1) / STEP;
                if (!s && mag > 64'h7FFF_FFFF) begin
                    r.data = 32'h7FFF_FFFF; r.inv = 1;
                end else if (s && mag > 64'h8000_0000) begin
                    r.data = 32'h8000_0000; r.inv = 1;
                end else begin
                    r.data = s ? 32'(-mag) : 32'(mag);
                    r.inx  = nz;
                end
            end
        end
        return r;
    endfunction

    // Monitor: pops one expectation per consumed result.
    bit          prev_vo = 0;
    int          rise_cyc = 0;
    logic [31:0] held = '0;
    always @(negedge Clk) begin
        exp_t x;
        if (!Rst_n) begin
            prev_vo = 0;
        end else begin
            if (Valid_Out && !prev_vo) begin
                rise_cyc = cyc;
                held     = Data_Out;
            end else if (Valid_Out) begin
                chk("hold_data", Data_Out, held);
            end
            if (Valid_Out) chk("busy_ready_out", 32'(Ready_Out), 32'd0);
            if (Valid_Out && Ready_In) begin
                if (exp_q.size() == 0) begin
                    ntot++;
                    $display("FAIL unexpected_result: got %h, expected no output", Data_Out);
                end else begin
                    x = exp_q.pop_front();
                    chk($sformatf("data[%h rm?]", x.din), Data_Out, x.data);
                    chk($sformatf("latency[%h]", x.din), 32'(rise_cyc - x.acc), 32'(x.lat));
`ifdef FP2INT_FLAGS_EN
                    chk($sformatf("invalid[%h]", x.din), 32'(Invalid), 32'(x.inv));
                    chk($sformatf("inexact[%h]", x.din), 32'(Inexact), 32'(x.inx));
`endif
                end
            end
            prev_vo = Valid_Out;
        end
    end

    task automatic issue(input logic [31:0] d, input logic [1:0] rm, output int waited);
        exp_t x;
        waited   = 0;
        Data_In  = d;
        RMode    = rm;
        Valid_In = 1'b1;
        while (!Ready_Out && waited < 200) begin
            if (rand_ready) Ready_In = ($urandom_range(0, 3) != 0);
            @(posedge Clk); #1;
            waited++;
        end
        if (!Ready_Out) begin
            chk("accept_timeout", 32'd0, 32'd1);
            Valid_In = 1'b0;
            return;
        end
        x     = model(d, rm);
        x.acc = cyc;
        exp_q.push_back(x);
        if (rand_ready) Ready_In = ($urandom_range(0, 3) != 0);
        @(posedge Clk); #1;
        Valid_In = 1'b0;
        Data_In  = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        Ready_In = 1'b1;
        while ((exp_q.size() != 0 || !Ready_Out) && n < 200) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    logic [33:0] dir [12] = '{
        {2'b00, 32'h4049_0FDB}, {2'b10, 32'h4049_0FDB},
        {2'b00, 32'hC020_0000}, {2'b01, 32'hC020_0000}, {2'b11, 32'hC020_0000},
        {2'b00, 32'h4F00_0000}, {2'b00, 32'hCF00_0000},
        {2'b00, 32'h7FC0_0000}, {2'b00, 32'h7F80_0000}, {2'b00, 32'h0000_0001},
        {2'b00, 32'h8000_0000}, {2'b00, 32'h3FC0_0000}
    };

    initial begin
        int          w, n;
        logic [31:0] r, d, bp_held;
        logic [33:0] ent;

        Valid_In = 1'b1;
        Data_In  = 32'h7FC0_0000;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_valid_out", 32'(Valid_Out), 32'd0);
        chk("reset_ready_out", 32'(Ready_Out), 32'd1);
        chk("reset_data_out", Data_Out, 32'd0);
        Valid_In = 1'b0;
        Rst_n    = 1'b1;
        Ready_In = 1'b1;
        @(posedge Clk); #1;

        for (int i = 0; i < 12; i++) begin
            ent = dir[i];
            issue(ent[31:0], ent[33:32], w);
        end
        drain();

        // Back-pressure with competing traffic on Data_In.
        Ready_In = 1'b0;
        issue(32'h4049_0FDB, 2'b00, w);
        n = 0;
        while (!Valid_Out && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("bp_valid_out", 32'(Valid_Out), 32'd1);
        bp_held = Data_Out;
        chk("bp_value", bp_held, 32'd3);
        for (int i = 0; i < 5; i++) begin
            Valid_In = 1'b1;
            Data_In  = $urandom;
            @(posedge Clk); #1;
            chk("bp_ready_out", 32'(Ready_Out), 32'd0);
            chk("bp_data_out", Data_Out, bp_held);
        end
        Ready_In = 1'b1;
        issue(32'hC020_0000, 2'b01, w);
        chk("bp_handoff_gap", 32'(w), 32'd1);
        drain();

        // Reset while aligning; the in-flight operand must vanish.
        issue(32'h3F00_0001, 2'b00, w);
        Rst_n    = 1'b0;
        Valid_In = 1'b1;
        Data_In  = 32'h7F80_0000;
        @(posedge Clk); #1;
        exp_q.delete();
        chk("midrst_valid_out", 32'(Valid_Out), 32'd0);
        chk("midrst_ready_out", 32'(Ready_Out), 32'd1);
        Rst_n    = 1'b1;
        Valid_In = 1'b0;
        @(posedge Clk); #1;
        chk("midrst_no_capture", 32'(Valid_Out), 32'd0);
        issue(32'h3F00_0001, 2'b00, w);
        drain();

        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            d = $urandom;
            if (r[1:0] != 2'b00) d[30:23] = 8'($urandom_range(100, 165));
            issue(d, r[3:2], w);
        end
        rand_ready = 0;
        drain();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
